switch_allocator: RTL and testbench
===================================

Name: switch_allocator

Overview:
- Separable two-stage round-robin switch allocator for one router.
- Takes switch_Req from every input-port/VC status buffer (with its computed output port and allocated downstream VC) and grants at most one VC per input port and one input per output port each cycle.
- Tracks per-downstream-VC credit counts so a flit is granted only when the downstream buffer has space.
- Drives the crossbar select and the read strobes back to the status buffers.

Parameters:
- PORT_NUM, 5, number of router ports (LOCAL, NORTH, SOUTH, EAST, WEST; index order of inout_Port).
- VC_NUM, 2**VC_Size, virtual channels per port.
- BUFFER_SIZE, 8, depth of each downstream VC buffer; initial and maximum credit count.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- switch_req_i  in  PORT_NUM*VC_NUM  switch request per input VC; held high until granted.
- port_req_i  in  PORT_NUM*VC_NUM x inout_Port  requested output port per input VC.
- vc_req_i  in  PORT_NUM*VC_NUM x VC_Size  allocated downstream VC per input VC.
- credit_i  in  PORT_NUM*VC_NUM  credit return pulse, indexed [output port][downstream VC].
- grant_o  out  PORT_NUM*VC_NUM  one-cycle read strobe to input VC buffer.
- xbar_sel_o  out  PORT_NUM x inout_Port  input port driving each output port.
- xbar_vld_o  out  PORT_NUM  output port carries a flit this cycle.
- xbar_vc_o  out  PORT_NUM x VC_Size  downstream VC tag for the outgoing flit.
- err_o  out  1  credit overflow or underflow detected (one-cycle pulse, registered).

Behaviour:
- Reset (async, rst=1):
  - grant_o=0, xbar_vld_o=0, xbar_sel_o=LOCAL, xbar_vc_o=0, err_o=0.
  - All credit counters = BUFFER_SIZE; all round-robin pointers = 0.
  - Reset mid-operation discards in-flight grants. Requests still high after reset are re-arbitrated from pointer 0.
- Eligibility: input VC (p,v) is eligible when switch_req_i[p][v]=1 and credit[port_req_i[p][v]][vc_req_i[p][v]] > 0.
- Stage 1 (input arbitration): per input port, a round-robin arbiter over its VC_NUM eligible VCs picks one candidate. Search starts at in_ptr[p].
- Stage 2 (output arbitration): per output port o, a round-robin arbiter over the PORT_NUM stage-1 candidates targeting o picks one winner. Search starts at out_ptr[o].
- Latency: arbitration is combinational from the registered credits and pointers. grant_o, xbar_sel_o, xbar_vld_o and xbar_vc_o are registered, so a request sampled in cycle N is answered in cycle N+1.
- Grant rules:
  - grant_o is a one-cycle pulse.
  - At most one grant per input port and at most one grant per output port per cycle.
  - A requester whose request is still high in cycle N+1 after its grant is re-arbitrated normally; the status buffer must drop or refresh its request.
- Pointers (update on a stage-2 win only):
  - in_ptr[p] moves to winner VC + 1 (mod VC_NUM).
  - out_ptr[o] moves to winning input + 1 (mod PORT_NUM).
  - A stage-1 candidate that loses stage 2 leaves in_ptr unchanged.
- Credits:
  - Counter width $clog2(BUFFER_SIZE+1).
  - Granted flit: decrement credit[o][vc] by 1 in the grant cycle.
  - credit_i pulse: increment by 1.
  - Simultaneous decrement and increment on the same counter: value unchanged.
  - Increment at BUFFER_SIZE: saturate and assert err_o next cycle.
  - Decrement at 0 cannot happen (eligibility gate); any such event is treated as an error as well.
- Illegal inputs:
  - A requester targeting its own input port is legal (U-turn not filtered).
  - port_req_i is don't-care when switch_req_i=0.

Decomposition:
- params_noc gets PORT_NUM, VC_NUM, credit-width localparam and a port_idx_t typedef; inout_Port and VC_Size are already there.
- One sub-module: rr_arbiter #(N), with request vector, pointer in, one-hot grant out and index out. It is instantiated PORT_NUM times for stage 1 (N=VC_NUM) and PORT_NUM times for stage 2 (N=PORT_NUM).

Test Plan:
- Reset then single request at input NORTH VC1 -> EAST, vc 0 -> cycle+1: grant_o[NORTH][1]=1, xbar_sel_o[EAST]=NORTH, xbar_vld_o[EAST]=1, xbar_vc_o[EAST]=0; credit[EAST][0]=7.
- LOCAL, NORTH and SOUTH all request WEST vc 1 continuously -> grants rotate LOCAL, NORTH, SOUTH, LOCAL…, one per cycle. Credit[WEST][1] reaches 0 after 8 grants and no further grant is issued until credit_i[WEST][1] pulses.
- Input EAST, both VCs requesting different outputs (NORTH, SOUTH) -> only one grant per cycle on input EAST, alternating VC0/VC1.
- Credit at 0, credit_i and a pending request in the same cycle -> credit becomes 1, grant next cycle, credit back to 0. Credit at 7 with simultaneous grant and credit_i -> stays 7.
- credit_i on a counter already at 8 -> err_o=1 for one cycle, counter stays 8.
- Assert rst mid-stream with requests held -> all outputs 0 and credits 8 immediately. After release, first grant goes to lowest-index requester.

Source files
------------

// File: rtl/switch_allocator_pkg.sv
// Shared router sizing, index types and port names for the switch allocator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package switch_allocator_pkg;

  localparam int VC_Size     = 1;
  localparam int VC_NUM      = 2 ** VC_Size;
  localparam int PORT_NUM    = 5;
  localparam int inout_Port  = $clog2(PORT_NUM);
  localparam int BUFFER_SIZE = 8;
  localparam int CRED_W      = $clog2(BUFFER_SIZE + 1);

  typedef logic [inout_Port-1:0] port_idx_t;
  typedef logic [VC_Size-1:0]    vc_idx_t;
  typedef logic [CRED_W-1:0]     cred_t;

  // Index order of every per-port vector in the router.
  typedef enum logic [inout_Port-1:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    EAST  = 3'd3,
    WEST  = 3'd4
  } port_e;

endpackage

// File: rtl/switch_allocator_if.sv
// Request/credit inputs and grant/crossbar outputs of the switch allocator.
// Latency: n/a (wiring only).
// Backpressure: credits returned on credit_i gate every grant.
interface switch_allocator_if;
  import switch_allocator_pkg::*;

  logic [PORT_NUM-1:0][VC_NUM-1:0]                 switch_req_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0][inout_Port-1:0] port_req_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_Size-1:0]    vc_req_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0]                 credit_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0]                 grant_o;
  logic [PORT_NUM-1:0][inout_Port-1:0]             xbar_sel_o;
  logic [PORT_NUM-1:0]                             xbar_vld_o;
  logic [PORT_NUM-1:0][VC_Size-1:0]                xbar_vc_o;
  logic                                            err_o;

  // Status buffers / downstream credit source side.
  modport master (
    output switch_req_i, port_req_i, vc_req_i, credit_i,
    input  grant_o, xbar_sel_o, xbar_vld_o, xbar_vc_o, err_o
  );

  // Allocator side.
  modport slave (
    input  switch_req_i, port_req_i, vc_req_i, credit_i,
    output grant_o, xbar_sel_o, xbar_vld_o, xbar_vc_o, err_o
  );

endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr, wrapping once.
// Latency: purely combinational.
// Backpressure: none; an empty request vector gives vld=0 and an all-zero grant.
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         vld
);

  // Scan upward from ptr modulo N; the first active request wins.
  always_comb begin
    int c;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    c   = 0;
    for (int i = 0; i < N; i++) begin
      c = (int'(ptr) + i) % N;
      if (!vld && req[c]) begin
        vld    = 1'b1;
        gnt[c] = 1'b1;
        idx    = W'(c);
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first round-robin switch allocator with downstream VC credit tracking.
// Latency: request sampled in cycle N is granted (grant/xbar outputs registered) in cycle N+1.
// Backpressure: a VC is only eligible while its downstream VC holds at least one credit.
module switch_allocator
  import switch_allocator_pkg::*;
(
  input logic               clk,
  input logic               rst,
  switch_allocator_if.slave bus
);

  cred_t                           cred       [PORT_NUM][VC_NUM];
  cred_t                           cred_nxt   [PORT_NUM][VC_NUM];
  vc_idx_t                         in_ptr     [PORT_NUM];
  vc_idx_t                         in_ptr_nxt [PORT_NUM];
  port_idx_t                       out_ptr    [PORT_NUM];
  port_idx_t                       out_ptr_nxt[PORT_NUM];

  logic [PORT_NUM-1:0][VC_NUM-1:0] elig;
  logic [VC_NUM-1:0]               s1_gnt     [PORT_NUM];
  vc_idx_t                         s1_idx     [PORT_NUM];
  logic [PORT_NUM-1:0]             s1_vld;
  port_idx_t                       cand_port  [PORT_NUM];
  logic [PORT_NUM-1:0]             s2_req     [PORT_NUM];
  logic [PORT_NUM-1:0]             s2_gnt     [PORT_NUM];
  port_idx_t                       s2_idx     [PORT_NUM];
  logic [PORT_NUM-1:0]             s2_vld;

  logic [PORT_NUM-1:0]             win_in;
  logic [PORT_NUM-1:0][VC_NUM-1:0] grant_nxt;
  port_idx_t                       sel_nxt    [PORT_NUM];
  vc_idx_t                         vc_nxt     [PORT_NUM];
  logic                            err_nxt;

  // A VC competes only if it requests a real port whose target downstream VC has credit.
  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        elig[p][v] = 1'b0;
        if (bus.switch_req_i[p][v] && (int'(bus.port_req_i[p][v]) < PORT_NUM)) begin
          elig[p][v] = (cred[bus.port_req_i[p][v]][bus.vc_req_i[p][v]] != '0);
        end
      end
    end
  end

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_s1
    rr_arbiter #(.N(VC_NUM)) u_arb (
      .req (elig[p]),
      .ptr (in_ptr[p]),
      .gnt (s1_gnt[p]),
      .idx (s1_idx[p]),
      .vld (s1_vld[p])
    );
  end

  // Output port targeted by each input port's stage-1 candidate.
  always_comb begin
    for (int p = 0; p < PORT_NUM; p++) begin
      cand_port[p] = bus.port_req_i[p][s1_idx[p]];
    end
  end

  // Per output port, the set of input ports whose candidate targets it.
  always_comb begin
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        s2_req[o][p] = s1_vld[p] && (cand_port[p] == port_idx_t'(o));
      end
    end
  end

  for (genvar o = 0; o < PORT_NUM; o++) begin : g_s2
    rr_arbiter #(.N(PORT_NUM)) u_arb (
      .req (s2_req[o]),
      .ptr (out_ptr[o]),
      .gnt (s2_gnt[o]),
      .idx (s2_idx[o]),
      .vld (s2_vld[o])
    );
  end

  // Fold stage-2 winners back into per-input grants, crossbar selects and pointer moves.
  always_comb begin
    win_in = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      win_in         = win_in | s2_gnt[o];
      sel_nxt[o]     = s2_vld[o] ? s2_idx[o] : port_idx_t'(LOCAL);
      vc_nxt[o]      = s2_vld[o] ? bus.vc_req_i[s2_idx[o]][s1_idx[s2_idx[o]]] : '0;
      out_ptr_nxt[o] = s2_vld[o] ? port_idx_t'((int'(s2_idx[o]) + 1) % PORT_NUM) : out_ptr[o];
    end
    for (int p = 0; p < PORT_NUM; p++) begin
      grant_nxt[p]  = win_in[p] ? s1_gnt[p] : '0;
      in_ptr_nxt[p] = win_in[p] ? vc_idx_t'((int'(s1_idx[p]) + 1) % VC_NUM) : in_ptr[p];
    end
  end

  // Credit bookkeeping: grant consumes, credit_i returns, both together cancel; over/underflow flags err.
  always_comb begin
    logic dec;
    logic inc;
    err_nxt = 1'b0;
    dec     = 1'b0;
    inc     = 1'b0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        cred_nxt[o][v] = cred[o][v];
        dec = s2_vld[o] && (vc_nxt[o] == vc_idx_t'(v));
        inc = bus.credit_i[o][v];
        if (inc && !dec) begin
          if (cred[o][v] == cred_t'(BUFFER_SIZE)) err_nxt = 1'b1;
          else                                    cred_nxt[o][v] = cred[o][v] + 1'b1;
        end else if (dec && !inc) begin
          if (cred[o][v] == '0) err_nxt = 1'b1;
          else                  cred_nxt[o][v] = cred[o][v] - 1'b1;
        end
      end
    end
  end

  // Register outputs, credits and arbitration pointers; reset drops in-flight grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.grant_o    <= '0;
      bus.xbar_vld_o <= '0;
      bus.err_o      <= 1'b0;
      for (int o = 0; o < PORT_NUM; o++) begin
        bus.xbar_sel_o[o] <= port_idx_t'(LOCAL);
        bus.xbar_vc_o[o]  <= '0;
        in_ptr[o]         <= '0;
        out_ptr[o]        <= '0;
        for (int v = 0; v < VC_NUM; v++) cred[o][v] <= cred_t'(BUFFER_SIZE);
      end
    end else begin
      bus.grant_o    <= grant_nxt;
      bus.xbar_vld_o <= s2_vld;
      bus.err_o      <= err_nxt;
      for (int o = 0; o < PORT_NUM; o++) begin
        bus.xbar_sel_o[o] <= sel_nxt[o];
        bus.xbar_vc_o[o]  <= vc_nxt[o];
        in_ptr[o]         <= in_ptr_nxt[o];
        out_ptr[o]        <= out_ptr_nxt[o];
        for (int v = 0; v < VC_NUM; v++) cred[o][v] <= cred_nxt[o][v];
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios plus random traffic against a queue-based reference model.
// Latency: expected outputs are queued when inputs are driven and compared one cycle later.
// Backpressure: credit returns are driven by the bench; grants are gated by the model's credit view.
module tb_switch_allocator;
  import switch_allocator_pkg::*;

  localparam int P_LOCAL = 0, P_NORTH = 1, P_SOUTH = 2, P_EAST = 3, P_WEST = 4;

  typedef struct {
    logic [PORT_NUM-1:0][VC_NUM-1:0]     grant;
    logic [PORT_NUM-1:0][inout_Port-1:0] sel;
    logic [PORT_NUM-1:0]                 vld;
    logic [PORT_NUM-1:0][VC_Size-1:0]    vc;
    logic                                err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  switch_allocator_if bus ();
  switch_allocator dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t expq[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // Staged stimulus for the next cycle.
  logic                            st_rst;
  logic [PORT_NUM-1:0][VC_NUM-1:0] st_req;
  logic [PORT_NUM-1:0][VC_NUM-1:0] st_cin;
  int                              st_port[PORT_NUM][VC_NUM];
  int                              st_vc  [PORT_NUM][VC_NUM];

  // Reference state: free slots per downstream VC and the next-preferred index of every arbiter.
  int m_cred[PORT_NUM][VC_NUM];
  int m_inp [PORT_NUM];
  int m_outp[PORT_NUM];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < PORT_NUM; o++) begin
      m_inp[o]  = 0;
      m_outp[o] = 0;
      for (int v = 0; v < VC_NUM; v++) m_cred[o][v] = BUFFER_SIZE;
    end
  endtask

  // Predict the registered outputs produced by the inputs being driven this cycle.
  task automatic model_and_push();
    exp_t e;
    int cand[PORT_NUM];
    int used[PORT_NUM][VC_NUM];
    int n;
    int win;
    e.grant = '0; e.sel = '0; e.vld = '0; e.vc = '0; e.err = 1'b0;
    if (st_rst) begin
      model_reset();
      expq.push_back(e);
      return;
    end
    for (int p = 0; p < PORT_NUM; p++) begin
      cand[p] = -1;
      for (int k = 0; k < VC_NUM; k++) begin
        n = (m_inp[p] + k) % VC_NUM;
        if (cand[p] < 0 && st_req[p][n] && m_cred[st_port[p][n]][st_vc[p][n]] > 0) cand[p] = n;
      end
      for (int v = 0; v < VC_NUM; v++) used[p][v] = 0;
    end
    for (int o = 0; o < PORT_NUM; o++) begin
      win = -1;
      for (int k = 0; k < PORT_NUM; k++) begin
        n = (m_outp[o] + k) % PORT_NUM;
        if (win < 0 && cand[n] >= 0 && st_port[n][cand[n]] == o) win = n;
      end
      if (win >= 0) begin
        e.grant[win][cand[win]] = 1'b1;
        e.sel[o] = inout_Port'(win);
        e.vld[o] = 1'b1;
        e.vc[o]  = VC_Size'(st_vc[win][cand[win]]);
        used[o][st_vc[win][cand[win]]] = 1;
        m_inp[win] = (cand[win] + 1) % VC_NUM;
        m_outp[o]  = (win + 1) % PORT_NUM;
      end
    end
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        n = m_cred[o][v] - used[o][v] + (st_cin[o][v] ? 1 : 0);
        if (n > BUFFER_SIZE) begin e.err = 1'b1; n = BUFFER_SIZE; end
        if (n < 0)           begin e.err = 1'b1; n = 0;           end
        m_cred[o][v] = n;
      end
    end
    expq.push_back(e);
  endtask

  // Drive one cycle of staged stimulus, queue its expectation, advance to just after the next negedge.
  task automatic step();
    rst = st_rst;
    bus.switch_req_i = st_req;
    bus.credit_i     = st_cin;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        bus.port_req_i[p][v] = inout_Port'(st_port[p][v]);
        bus.vc_req_i[p][v]   = VC_Size'(st_vc[p][v]);
      end
    end
    model_and_push();
    st_cin = '0;
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input int v, input int o, input int dv);
    st_req[p][v]  = 1'b1;
    st_port[p][v] = o;
    st_vc[p][v]   = dv;
  endtask

  // Monitor: every negedge, compare the DUT outputs with the oldest queued expectation.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      check("grant", 32'(bus.grant_o),    32'(mon_e.grant));
      check("sel",   32'(bus.xbar_sel_o), 32'(mon_e.sel));
      check("vld",   32'(bus.xbar_vld_o), 32'(mon_e.vld));
      check("vc",    32'(bus.xbar_vc_o),  32'(mon_e.vc));
      check("err",   32'(bus.err_o),      32'(mon_e.err));
    end
  end

  initial begin
    rst    = 1'b1;
    st_rst = 1'b1;
    st_req = '0;
    st_cin = '0;
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_NUM; v++) begin st_port[p][v] = 0; st_vc[p][v] = 0; end
    bus.switch_req_i = '0; bus.credit_i = '0; bus.port_req_i = '0; bus.vc_req_i = '0;
    model_reset();
    @(negedge clk); #1;
    step(); step();
    check("rst_grant", 32'(bus.grant_o), 32'h0);
    check("rst_vld",   32'(bus.xbar_vld_o), 32'h0);
    st_rst = 1'b0;
    step();

    // Single request NORTH VC1 -> EAST downstream VC0.
    set_req(P_NORTH, 1, P_EAST, 0);
    step();
    check("t1_grant", 32'(bus.grant_o),    32'h8);
    check("t1_sel",   32'(bus.xbar_sel_o), 32'h200);
    check("t1_vld",   32'(bus.xbar_vld_o), 32'h8);
    check("t1_vc",    32'(bus.xbar_vc_o),  32'h0);
    st_req = '0;
    step();

    // Three inputs contend for WEST VC1 until its credits run out.
    set_req(P_LOCAL, 0, P_WEST, 1);
    set_req(P_NORTH, 0, P_WEST, 1);
    set_req(P_SOUTH, 0, P_WEST, 1);
    step();
    check("rr_first", 32'(bus.grant_o), 32'h1);
    for (int i = 0; i < 10; i++) step();
    check("starved_grant", 32'(bus.grant_o), 32'h0);
    st_cin[P_WEST][1] = 1'b1;
    step();
    step();
    check("refill_grant", 32'(bus.grant_o), 32'h10);
    step();
    check("redrain_grant", 32'(bus.grant_o), 32'h0);
    st_req = '0;
    step();

    // EAST credit is 7: concurrent consume and return leaves it at 7, then fill to 8 and overflow.
    set_req(P_LOCAL, 0, P_EAST, 0);
    st_cin[P_EAST][0] = 1'b1;
    step();
    st_req = '0;
    st_cin[P_EAST][0] = 1'b1;
    step();
    check("no_err_at_full", 32'(bus.err_o), 32'h0);
    st_cin[P_EAST][0] = 1'b1;
    step();
    check("overflow_err", 32'(bus.err_o), 32'h1);
    step();
    check("err_pulse", 32'(bus.err_o), 32'h0);

    // Input EAST, both VCs to different outputs: one grant per cycle, alternating VCs.
    set_req(P_EAST, 0, P_NORTH, 0);
    set_req(P_EAST, 1, P_SOUTH, 1);
    for (int i = 0; i < 6; i++) step();
    st_req = '0;
    step();

    // Reset in the middle of held traffic.
    set_req(P_LOCAL, 1, P_EAST, 1);
    set_req(P_SOUTH, 0, P_EAST, 1);
    set_req(P_WEST,  0, P_NORTH, 0);
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    #1;
    check("async_rst_grant", 32'(bus.grant_o),    32'h0);
    check("async_rst_vld",   32'(bus.xbar_vld_o), 32'h0);
    check("async_rst_sel",   32'(bus.xbar_sel_o), 32'h0);
    st_rst = 1'b1;
    step();
    st_rst = 1'b0;
    step();
    check("post_rst_grant", 32'(bus.grant_o), 32'h102);
    st_req = '0;
    step();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          st_req[p][v]  = ($urandom_range(0, 3) != 0);
          st_port[p][v] = $urandom_range(0, PORT_NUM - 1);
          st_vc[p][v]   = $urandom_range(0, VC_NUM - 1);
          st_cin[p][v]  = ($urandom_range(0, 5) == 0);
        end
      end
      step();
    end
    st_req = '0;
    step();
    step();
    check("queue_drained", 32'(expq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
